// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - operand/result handshake bundle for the bit-serial adder/subtractor
//
// Signals:
//   in_valid / in_ready    operand handshake (a, b, sub sampled on the accept edge)
//   a, b                   WIDTH-bit operands
//   sub                    0 = a+b, 1 = a-b
//   out_valid / out_ready  result handshake
//   sum, carry_out         WIDTH-bit result and final carry
//   ovf                    signed overflow, present only with SERIAL_ADD_SUB_OVF_EN
// Modports: master = operand producer / result consumer, slave = arithmetic unit.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out
`ifdef SERIAL_ADD_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out
`ifdef SERIAL_ADD_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, one full-adder cell and a carry flop, LSB first
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      serial_add_sub_if.slave: in_valid/in_ready/a/b/sub in, out_valid/out_ready/sum/carry_out out
// Optional: define SERIAL_ADD_SUB_OVF_EN to add bus.ovf (signed two's-complement overflow).
// Timing: accept at edge E0, out_valid high after edge E0+WIDTH, held until out_ready.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_sub_if.slave       bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_s;
    logic               fa_c;

    // The single full-adder cell working on the current LSBs.
    always_comb begin
        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction = add the one's complement of b with carry-in 1.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b ^ {WIDTH{bus.sub}};
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d  = {fa_s, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = fa_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    // On the MSB step c_q is the carry into the sign bit.
                    ovf_d   = c_q ^ fa_c;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed vector bench for serial_add_sub (WIDTH=8)
module tb_serial_add_sub;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    serial_add_sub_if #(.WIDTH(W)) bus ();
    serial_add_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one operation at a negedge and waits for out_valid.
    // Returns the number of edges from accept to out_valid (budget+1 on timeout).
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input logic ordy, output int lat);
        chk("in_ready_before", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = s;
        bus.out_ready = ordy;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.sub      = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= W + 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) lat = W + 7;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_sum"},  {24'd0, bus.sum}, {24'd0, v.sum});
        chk({tag, "_cout"}, {31'd0, bus.carry_out}, {31'd0, v.cout});
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk({tag, "_ovf"},  {31'd0, bus.ovf}, {31'd0, v.ovf});
`endif
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [W-1:0] held_sum;
        logic         held_cout;

        n_vec  = 0;
        n_miss = 0;
        //        a      b      sub   sum    cout  ovf
        vt[0]  = '{8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1};
        vt[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
        vt[4]  = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[5]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vt[6]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[7]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[8]  = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        vt[9]  = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[10] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[11] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum",       {24'd0, bus.sum}, 32'd0);
        chk("rst_cout",      {31'd0, bus.carry_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: latency, result, one-cycle out_valid, in_ready return.
        for (int i = 0; i < 12; i++) begin
            v = vt[i];
            start_and_wait(v.a, v.b, v.sub, 1'b1, lat);
            chk($sformatf("v%0d_latency", i), lat, W);
            check_result($sformatf("v%0d", i), v);
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), {31'd0, bus.out_valid}, 32'd0);
            chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            chk($sformatf("v%0d_sum_kept", i), {24'd0, bus.sum}, {24'd0, v.sum});
        end

        // Backpressure: hold result in DONE while inputs churn.
        start_and_wait(8'h3C, 8'h45, 1'b0, 1'b0, lat);
        chk("bp_latency", lat, W);
        held_sum  = bus.sum;
        held_cout = bus.carry_out;
        chk("bp_sum", {24'd0, held_sum}, 32'h81);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.sub      = 1'($urandom);
            @(negedge clk);
            chk($sformatf("bp%0d_sum", k), {24'd0, bus.sum}, 32'h81);
            chk($sformatf("bp%0d_cout", k), {31'd0, bus.carry_out}, 32'd0);
            chk($sformatf("bp%0d_out_valid", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_rel_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("bp_rel_sum",       {24'd0, bus.sum}, 32'h81);

        // Reset three edges into RUN, then a clean operation.
        bus.in_valid = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.sub      = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_run_busy", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_sum",       {24'd0, bus.sum}, 32'd0);
        chk("mid_rst_cout",      {31'd0, bus.carry_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = vt[5];
        start_and_wait(v.a, v.b, v.sub, 1'b1, lat);
        chk("post_rst_latency", lat, W);
        check_result("post_rst", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor built around one full-adder cell and a carry flip-flop.
- Subtraction is the inverse direction of the adder: invert b and seed the carry with 1.
- Processes one bit per clock, LSB first, behind a valid/ready handshake on both input and output.
- Sits in the ARITHMETIC group as the area-cheap counterpart to the ripple adders, for ALU paths that can afford WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b and sub are presented.
- in_ready  output  1  block can accept operands; equals (state==IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result is valid; equals (state==DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  final carry. For add: unsigned overflow. For sub: 1 = no borrow (A>=B unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sum=0, carry_out=0, internal shift registers=0, carry flop=0, bit counter=0.
  - Consequently in_ready=1 and out_valid=0.
- Reset mid-RUN or mid-DONE aborts the operation; the result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - Input handshake (in_valid && in_ready) at edge E0 latches a into a_sh and (b XOR {WIDTH{sub}}) into b_sh.
  - Same edge sets carry flop = sub, clears bit counter, goes to RUN.
  - No handshake: state holds.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^c; c_next = majority(a_sh[0], b_sh[0], c).
  - Result register shifts right with s entering at the MSB.
  - a_sh and b_sh shift right by one; counter increments.
  - On the edge where counter == WIDTH-1: load sum from the completed result, set carry_out = c_next, go to DONE.
  - RUN lasts exactly WIDTH edges, so out_valid is first high after edge E0+WIDTH.
  - in_valid is ignored in RUN and DONE; in_ready is 0 there.
- DONE:
  - out_valid=1; sum and carry_out are held stable until out_ready=1.
  - An edge with out_ready=1 returns to IDLE.
  - in_ready rises the cycle after the output handshake; there is no same-cycle turnaround.
  - Minimum initiation interval is WIDTH+2 cycles.
- After returning to IDLE, sum and carry_out keep the last result until the next DONE load.
- out_ready asserted outside DONE has no effect.
- Arithmetic: result equals (a + (sub ? ~b : b) + sub) mod 2^WIDTH; carry_out is bit WIDTH of that sum.
- The operand registers are the only sampling point: a, b and sub may change freely after the input handshake.

Optional Feature:
- Macro SERIAL_ADD_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit): signed two's-complement overflow.
  - On the final RUN edge, ovf is captured as (carry into the MSB bit) XOR c_next.
  - ovf is loaded and held with sum; reset value 0.
- Undefined: no ovf port and no extra flop; behaviour is otherwise identical.

Test Plan:
- Latency, WIDTH=8, add 0x3C+0x45 with out_ready=1 → sum=0x81, carry_out=0; out_valid first high 8 cycles after the accept edge, for 1 cycle; in_ready back to 1 one cycle later.
- Add 0xFF+0x01 → sum=0x00, carry_out=1. Add 0x00+0x00 → sum=0x00, carry_out=0.
- Subtract 0x10-0x01 → sum=0x0F, carry_out=1. Subtract 0x01-0x02 → sum=0xFF, carry_out=0 (borrow).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b → sum/carry_out stable, out_valid stays 1, in_ready stays 0, no new operands accepted; release → IDLE next cycle.
- Reset mid-operation: drop rst_n 3 cycles into RUN → immediately in_ready=1, out_valid=0, sum=0, carry_out=0; the next operation 0x12+0x34 gives 0x46 cleanly.
- With SERIAL_ADD_SUB_OVF_EN: 0x7F+0x01 → sum=0x80, ovf=1. 0x80-0x01 → sum=0x7F, ovf=1. 0x05-0x03 → ovf=0.
